mem_sync_param: RTL and testbench
=================================

Name: mem_sync_param

Overview:
Parametrised single-port synchronous memory. It generalises the team's 32x16 controller memory in width, depth and read latency, and adds byte-enable writes. It also adds a request/ready handshake, a read-valid strobe, address range checking and a hardware clear engine. It sits behind the bus controller as its local data store and replaces fixed-size memory instances.

Parameters:
DW, 16, data width in bits; multiple of 8
AW, 5, address width in bits
DEPTH, 32, number of words; 1 <= DEPTH <= 2**AW (non-power-of-2 allowed)
READ_LAT, 1, read latency in cycles from accept to RVALID; legal values 1 or 2
BW, DW/8, derived; number of byte lanes

Ports:
CLK  input  1  clock; all logic on rising edge
RST_N  input  1  asynchronous active-low reset
REQ  input  1  access request
WE  input  1  1 = write, 0 = read; sampled with REQ
ADDR  input  AW  word address
WDATA  input  DW  write data
BE  input  BW  byte enables for writes; bit i covers WDATA[8i+7:8i]
CLR  input  1  synchronous request to zero the whole memory
READY  output  1  block accepts an access this cycle
RDATA  output  DW  read data
RVALID  output  1  one-cycle strobe marking RDATA valid
ERR  output  1  one-cycle strobe for an out-of-range access

Behaviour:
- Reset (RST_N low, asynchronous):
  - READY=0, RVALID=0, ERR=0, RDATA=0.
  - Read pipeline flushed; clear pointer = 0; FSM enters CLEAR.
  - Array contents undefined until CLEAR completes.
- FSM states: CLEAR, IDLE.
  - CLEAR: writes zero to address ptr and increments ptr by 1 each cycle, covering 0..DEPTH-1. This takes exactly DEPTH cycles.
  - CLEAR -> IDLE after the last write. READY is registered and equals (state==IDLE), so READY rises on the cycle after the address DEPTH-1 write.
  - IDLE -> CLEAR when CLR=1. ptr resets to 0 and READY falls the next cycle.
  - CLR during CLEAR is ignored; the sweep does not restart.
  - Reset asserted mid-CLEAR or mid-IDLE restarts the sweep from 0 after release.
- Accept condition: accept = REQ & READY & ~CLR. CLR wins over a same-cycle REQ; that request is dropped and not queued. REQ while READY=0 is ignored, not queued.
- Write (accept & WE): only lanes with BE[i]=1 are updated, on the accept edge. BE=0 is a legal no-op.
- Read (accept & ~WE):
  - RDATA and RVALID appear READ_LAT cycles after the accept edge. READ_LAT=2 adds one output register stage.
  - RVALID is high for exactly one cycle per read. RDATA holds its last value when RVALID=0.
- Throughput: one access per cycle, with back-to-back reads and writes in any mix.
  - A read accepted the cycle after a write to the same address returns the new data.
  - Reads already in flight when CLR is asserted complete normally with pre-clear data.
- Range check: ADDR >= DEPTH is out of range.
  - Write: the array is unchanged and ERR pulses 1 cycle after accept.
  - Read: RDATA=0 with RVALID=1, and ERR pulses in the same cycle as RVALID.
  - For DEPTH = 2**AW, ERR never asserts.
- Address wrap: no auto-increment; ADDR is used as given, and the clear pointer stops at DEPTH-1.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
1. Reset release, DEPTH=32 -> READY=0 for 32 cycles and rises on cycle 33; reads of addresses 0, 17 and 31 return 0x0000 with RVALID exactly 1 cycle after accept (READ_LAT=1).
2. Write 0xABCD to addr 5 with BE=2'b11, then write 0x1200 with BE=2'b10, then read addr 5 -> RDATA=0x12CD.
3. Back-to-back reads of addr 1, 2, 3 on consecutive cycles with READ_LAT=2 (contents 0x0011, 0x0022, 0x0033) -> RVALID high for 3 consecutive cycles starting 2 cycles after the first accept, in order.
4. DEPTH=24, AW=5: read addr 30 -> RDATA=0 with RVALID=1 and ERR=1; write 0xFFFF to addr 24 -> ERR one cycle later and addr 24 not created; a read of addr 23 is unaffected.
5. Write 0x5555 to addr 9, then pulse CLR together with a write of 0x7777 to addr 10 -> write dropped, READY low for DEPTH cycles, then reads of addrs 9 and 10 return 0.
6. Assert RST_N low midway through CLEAR (ptr=12) -> outputs zero immediately; after release READY stays low for a full DEPTH cycles, then all addresses read 0.

Source files
------------

// File: rtl/mem_sync_param.sv
// Parametrised single-port synchronous memory: byte-enable writes, req/ready
// handshake, 1- or 2-cycle read latency, address range checking, and a
// hardware sweep that zeroes every word after reset or on clr_i.
//
// state    | meaning
// ST_CLEAR | writing zero to ptr_q each cycle, 0..DEPTH-1; no accesses
// ST_IDLE  | accepting one read or write per cycle
module mem_sync_param #(
  parameter int DW       = 16,
  parameter int AW       = 5,
  parameter int DEPTH    = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   be_i,
  input  logic              clr_i,
  output logic              ready_o,
  output logic [DW-1:0]     rdata_o,
  output logic              rvalid_o,
  output logic              err_o
);

  localparam int BW = DW / 8;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ready_q;
  logic            rvalid_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;

  logic [DW-1:0]   mem_q [DEPTH];

  logic            sweep_we;
  logic            accept;
  logic            wr_acc;
  logic            rd_acc;
  logic            in_range;
  logic            wr_err;
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   wr_word;

  // Read result arriving at the output registers on the next edge.
  logic            fin_v;
  logic            fin_e;
  logic [DW-1:0]   fin_d;

  // ready_q mirrors state_q == ST_IDLE, so it blocks accesses during the sweep.
  assign accept = req_i & ready_q & ~clr_i;
  assign wr_acc = accept & we_i;
  assign rd_acc = accept & ~we_i;

  generate
    if (DEPTH >= (1 << AW)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = ({1'b0, addr_i} < (AW+1)'(DEPTH));
    end
  endgenerate

  assign wr_err  = wr_acc & ~in_range;
  assign rd_word = in_range ? mem_q[addr_i] : '0;

  // Merge enabled byte lanes of the write data over the current word.
  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < BW; b++) begin
      if (be_i[b]) begin
        wr_word[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  // Next-state logic: sweep pointer walks 0..DEPTH-1 then parks at the last word.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sweep_we = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sweep_we = 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // State, sweep pointer and registered ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Storage array; no reset, contents are defined once the sweep finishes.
  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_acc && in_range) begin
      mem_q[addr_i] <= wr_word;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic          s1_v_q;
      logic          s1_e_q;
      logic [DW-1:0] s1_d_q;

      // Extra read stage: capture the word at the accept edge, present it one cycle later.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          s1_v_q <= 1'b0;
          s1_e_q <= 1'b0;
          s1_d_q <= '0;
        end else begin
          s1_v_q <= rd_acc;
          s1_e_q <= rd_acc & ~in_range;
          if (rd_acc) begin
            s1_d_q <= rd_word;
          end
        end
      end

      assign fin_v = s1_v_q;
      assign fin_e = s1_e_q;
      assign fin_d = s1_d_q;
    end else begin : g_lat1
      assign fin_v = rd_acc;
      assign fin_e = rd_acc & ~in_range;
      assign fin_d = rd_word;
    end
  endgenerate

  // Output registers; rdata holds its last value between read strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= fin_v;
      err_q    <= wr_err | fin_e;
      if (fin_v) begin
        rdata_q <= fin_d;
      end
    end
  end

  assign ready_o  = ready_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_sync_param.sv
// Bench for mem_sync_param: two instances share one stimulus stream,
// a = (DEPTH 32, READ_LAT 1), b = (DEPTH 24, READ_LAT 2).
module tb_mem_sync_param;

  localparam int DW = 16;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic req   = 1'b0;
  logic we    = 1'b0;
  logic clr   = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    be    = '0;

  logic [1:0]          d_ready;
  logic [1:0]          d_rvalid;
  logic [1:0]          d_err;
  logic [1:0][DW-1:0]  d_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_edge = 0;

  // Reference model state, per instance.
  bit [1:0]      e_ready;
  bit [1:0]      e_rvalid;
  bit [1:0]      e_err;
  logic [DW-1:0] e_rdata [2];
  logic [DW-1:0] m_mem [2][32];
  int            m_clr_left [2];
  // Read results scheduled by the edge number at which they must appear.
  bit            sch_v [2][8];
  bit            sch_e [2][8];
  logic [DW-1:0] sch_d [2][8];

  always #5 clk = ~clk;

  mem_sync_param #(.DW(16), .AW(5), .DEPTH(32), .READ_LAT(1)) u_dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .clr_i   (clr),
    .ready_o (d_ready[0]),
    .rdata_o (d_rdata[0]),
    .rvalid_o(d_rvalid[0]),
    .err_o   (d_err[0])
  );

  mem_sync_param #(.DW(16), .AW(5), .DEPTH(24), .READ_LAT(2)) u_dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .clr_i   (clr),
    .ready_o (d_ready[1]),
    .rdata_o (d_rdata[1]),
    .rvalid_o(d_rvalid[1]),
    .err_o   (d_err[1])
  );

  function automatic int depth_of(int k);
    return (k == 0) ? 32 : 24;
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      e_ready[k]    = 1'b0;
      e_rvalid[k]   = 1'b0;
      e_err[k]      = 1'b0;
      e_rdata[k]    = '0;
      m_clr_left[k] = depth_of(k);
      for (int a = 0; a < 32; a++) m_mem[k][a] = '0;
      for (int s = 0; s < 8; s++) sch_v[k][s] = 1'b0;
    end
  endtask

  // One rising edge of the reference, using the inputs held before the edge.
  task automatic model_edge(int k);
    bit acc;
    bit oor;
    bit werr;
    int a;
    int slot;
    a    = int'(addr);
    acc  = req && e_ready[k] && !clr;
    oor  = (a >= depth_of(k));
    werr = 1'b0;
    if (acc && we) begin
      if (oor) werr = 1'b1;
      else begin
        for (int b = 0; b < 2; b++)
          if (be[b]) m_mem[k][a][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (acc && !we) begin
      slot = (n_edge + lat_of(k) - 1) % 8;
      sch_v[k][slot] = 1'b1;
      sch_e[k][slot] = oor;
      sch_d[k][slot] = oor ? 16'h0000 : m_mem[k][a];
    end
    slot = n_edge % 8;
    e_rvalid[k] = sch_v[k][slot];
    if (sch_v[k][slot]) e_rdata[k] = sch_d[k][slot];
    e_err[k] = werr | (sch_v[k][slot] & sch_e[k][slot]);
    sch_v[k][slot] = 1'b0;
    if (m_clr_left[k] > 0) begin
      m_clr_left[k]--;
      e_ready[k] = (m_clr_left[k] == 0);
    end else if (clr) begin
      m_clr_left[k] = depth_of(k);
      e_ready[k]    = 1'b0;
      for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready_%0d", k),  {31'd0, d_ready[k]},  {31'd0, e_ready[k]});
      chk($sformatf("rvalid_%0d", k), {31'd0, d_rvalid[k]}, {31'd0, e_rvalid[k]});
      chk($sformatf("err_%0d", k),    {31'd0, d_err[k]},    {31'd0, e_err[k]});
      chk($sformatf("rdata_%0d", k),  {16'd0, d_rdata[k]},  {16'd0, e_rdata[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      for (int k = 0; k < 2; k++) model_edge(k);
      n_edge++;
    end
    #1;
    check_all();
  endtask

  task automatic drive(bit r, bit w, int a, int d, int b, bit c);
    req   = r;
    we    = w;
    addr  = a[AW-1:0];
    wdata = d[DW-1:0];
    be    = b[1:0];
    clr   = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    int cyc;
    int t1a [3];
    t1a = '{0, 17, 31};

    // Reset values
    model_reset();
    idle();
    #2 rst_n = 1'b0;
    #1 check_all();
    tick();
    tick();
    rst_n = 1'b1;

    // 1: sweep length after reset release, then reads of cleared words
    cyc = 0;
    while (d_ready[0] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t1_ready_rise_cycles", cyc, 32);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, t1a[i], 0, 0, 1'b0);
      tick();
      chk("t1_rvalid_lat1", {31'd0, d_rvalid[0]}, 1);
      chk("t1_rdata_zero", {16'd0, d_rdata[0]}, 0);
    end
    idle();
    tick();
    tick();

    // 2: byte-enable merge
    drive(1'b1, 1'b1, 5, 'hABCD, 3, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5, 'h1200, 2, 1'b0);
    tick();
    drive(1'b1, 1'b0, 5, 0, 0, 1'b0);
    tick();
    chk("t2_rdata_a", {16'd0, d_rdata[0]}, 'h12CD);
    idle();
    tick();
    chk("t2_rdata_b", {16'd0, d_rdata[1]}, 'h12CD);

    // 3: back-to-back reads, latency 2 on instance b
    drive(1'b1, 1'b1, 1, 'h0011, 3, 1'b0); tick();
    drive(1'b1, 1'b1, 2, 'h0022, 3, 1'b0); tick();
    drive(1'b1, 1'b1, 3, 'h0033, 3, 1'b0); tick();
    idle();
    tick();
    tick();
    drive(1'b1, 1'b0, 1, 0, 0, 1'b0); tick();
    chk("t3_rvalid_b_early", {31'd0, d_rvalid[1]}, 0);
    drive(1'b1, 1'b0, 2, 0, 0, 1'b0); tick();
    chk("t3_rd1_b", {15'd0, d_rvalid[1], d_rdata[1]}, 'h10011);
    drive(1'b1, 1'b0, 3, 0, 0, 1'b0); tick();
    chk("t3_rd2_b", {15'd0, d_rvalid[1], d_rdata[1]}, 'h10022);
    idle(); tick();
    chk("t3_rd3_b", {15'd0, d_rvalid[1], d_rdata[1]}, 'h10033);
    tick();
    chk("t3_rvalid_b_end", {31'd0, d_rvalid[1]}, 0);

    // 4: out-of-range on the 24-word instance
    drive(1'b1, 1'b1, 23, 'h2323, 3, 1'b0); tick();
    drive(1'b1, 1'b0, 30, 0, 0, 1'b0); tick();
    chk("t4_err_a_rd30", {31'd0, d_err[0]}, 0);
    idle(); tick();
    chk("t4_rd30_b", {14'd0, d_err[1], d_rvalid[1], d_rdata[1]}, 'h30000);
    drive(1'b1, 1'b1, 24, 'hFFFF, 3, 1'b0); tick();
    chk("t4_wr24_err_b", {31'd0, d_err[1]}, 1);
    chk("t4_wr24_err_a", {31'd0, d_err[0]}, 0);
    idle(); tick();
    drive(1'b1, 1'b0, 24, 0, 0, 1'b0); tick();
    chk("t4_rd24_a", {16'd0, d_rdata[0]}, 'hFFFF);
    idle(); tick();
    chk("t4_rd24_b", {14'd0, d_err[1], d_rvalid[1], d_rdata[1]}, 'h30000);
    drive(1'b1, 1'b0, 23, 0, 0, 1'b0); tick();
    idle(); tick();
    chk("t4_rd23_b", {14'd0, d_err[1], d_rvalid[1], d_rdata[1]}, 'h12323);

    // 5: clear wins over a same-cycle write; in-flight read keeps old data
    drive(1'b1, 1'b1, 9, 'h5555, 3, 1'b0); tick();
    drive(1'b1, 1'b0, 9, 0, 0, 1'b0); tick();
    chk("t5_rd9_a", {16'd0, d_rdata[0]}, 'h5555);
    drive(1'b1, 1'b1, 10, 'h7777, 3, 1'b1); tick();
    chk("t5_inflight_b", {15'd0, d_rvalid[1], d_rdata[1]}, 'h15555);
    chk("t5_ready_fall_a", {31'd0, d_ready[0]}, 0);
    idle();
    cyc = 0;
    while (d_ready[0] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t5_clear_cycles", cyc, 32);
    drive(1'b1, 1'b0, 9, 0, 0, 1'b0); tick();
    chk("t5_rd9_cleared", {16'd0, d_rdata[0]}, 0);
    drive(1'b1, 1'b0, 10, 0, 0, 1'b0); tick();
    chk("t5_rd10_dropped", {16'd0, d_rdata[0]}, 0);
    idle(); tick(); tick();

    // 6: reset in the middle of a sweep
    drive(1'b1, 1'b1, 7, 'hBEEF, 3, 1'b0); tick();
    drive(1'b1, 1'b0, 7, 0, 0, 1'b0); tick();
    idle(); tick(); tick();
    chk("t6_pre_rdata_a", {16'd0, d_rdata[0]}, 'hBEEF);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1); tick();
    idle();
    repeat (12) tick();
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("t6_async_rdata_a", {16'd0, d_rdata[0]}, 0);
    chk("t6_async_ready_a", {31'd0, d_ready[0]}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    cyc = 0;
    while (d_ready[0] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t6_full_sweep_cycles", cyc, 32);
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 1'b0, a, 0, 0, 1'b0);
      tick();
      chk("t6_rd_zero_a", {15'd0, d_rvalid[0], d_rdata[0]}, 'h10000);
    end
    idle(); tick(); tick();

    // Randomised traffic against the reference model
    for (int i = 0; i < 700; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 31)), int'($urandom), int'($urandom_range(0, 3)),
            $urandom_range(0, 127) == 0);
      tick();
    end
    idle();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
